logic_gates_checker: RTL

- Synthesizable self-test engine that acts as the response side of the two-input gate block interface.
- Drives the four (a,b) vectors into the gate block and samples the seven gate outputs y1..y7.
- Compares each sample against golden values, accumulates errors, and reports a pass/fail verdict.
- Sits beside the gate block in the top level; replaces free-running bench stimulus with a start/done handshake.

---
 rtl/logic_gates_pkg.sv | 39 +++
 rtl/gate_golden_model.sv | 11 +
 rtl/logic_gates_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/logic_gates_pkg.sv
// Shared types and helpers for the two-input gate block self-test engine.
package logic_gates_pkg;

  // Checker sequencing states
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  // Number of (a,b) stimulus vectors applied per run
  localparam int NUM_VECTORS = 4;

  // Bit positions of each gate output within the packed {y7..y1} bus
  localparam int Y_AND   = 0;
  localparam int Y_OR    = 1;
  localparam int Y_NOT_A = 2;
  localparam int Y_NAND  = 3;
  localparam int Y_NOR   = 4;
  localparam int Y_XOR   = 5;
  localparam int Y_XNOR  = 6;

  // Reference response of a correct gate block for one (a,b) pair
  function automatic logic [6:0] golden(input logic a, input logic b);
    logic [6:0] y;
    y          = '0;
    y[Y_AND]   = a & b;
    y[Y_OR]    = a | b;
    y[Y_NOT_A] = ~a;
    y[Y_NAND]  = ~(a & b);
    y[Y_NOR]   = ~(a | b);
    y[Y_XOR]   = a ^ b;
    y[Y_XNOR]  = ~(a ^ b);
    return y;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Purely combinational reference model of the two-input gate block.
module gate_golden_model
  import logic_gates_pkg::*;
(
  input  logic [1:0] ab,
  output logic [6:0] y
);

  assign y = golden(ab[1], ab[0]);

endmodule

// File: rtl/logic_gates_checker.sv
// Self-test engine: walks the four (a,b) vectors through the gate block,
// compares each settled response against the golden model and reports a verdict.
module logic_gates_checker
  import logic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [6:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask,
  output logic [1:0]       first_fail
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST_VECTOR = 2'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t     state;
  state_t     state_next;
  logic [1:0] vec_idx;
  logic [3:0] settle_cnt;
  logic [1:0] ab_q;
  logic       pass_q;
  logic [6:0] gold;
  logic [6:0] diff;
  logic       mismatch;
  logic       last_vec;
  logic [ERR_W-1:0] err_inc;

  // Golden response is taken from the registered stimulus, so it lines up
  // with what the gate block is actually being driven with
  gate_golden_model u_golden (
    .ab (ab_q),
    .y  (gold)
  );

  assign diff     = y_in ^ gold;
  assign mismatch = |diff;
  assign last_vec = (vec_idx == LAST_VECTOR);
  assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

  assign a    = ab_q[1];
  assign b    = ab_q[0];
  assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == FINISH);
  assign pass = pass_q;

  // State register; reset drops straight back to IDLE, abandoning any run
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing: drive, wait out the settle time, sample, repeat
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   state_next = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0) state_next = SAMPLE;
      SAMPLE:  state_next = last_vec ? FINISH : DRIVE;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stimulus, settle timer and result accumulation for the current run
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx    <= '0;
      settle_cnt <= '0;
      ab_q       <= '0;
      pass_q     <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_idx    <= '0;
            pass_q     <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
            first_fail <= '0;
          end
        end
        DRIVE: begin
          ab_q       <= vec_idx;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_inc;
            fail_mask <= fail_mask | diff;
            if (err_count == '0) begin
              first_fail <= ab_q;
            end
          end
          if (last_vec) begin
            pass_q <= (err_count == '0) && !mismatch;
          end else begin
            vec_idx <= vec_idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
